// File: rtl/shift_reg_unit_if.sv
// Handshake and data bundle between the shift-source logic and shift_reg_unit.
interface shift_reg_unit_if;
  logic        start;
  logic [1:0]  shift_op;
  logic [4:0]  shift_amt;
  logic [31:0] shift_in;
  logic [31:0] shift_out;
  logic        busy;
  logic        done;

  modport master (
    output start, shift_op, shift_amt, shift_in,
    input  shift_out, busy, done
  );

  modport slave (
    input  start, shift_op, shift_amt, shift_in,
    output shift_out, busy, done
  );
endinterface

// File: rtl/shift_reg_unit.sv
// Iterative 32-bit shifter: one bit per clock, captured operand/op/amount,
// down-counter terminates the shift and a single-cycle done pulse follows.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; shift_out holds the last result
// SHIFT | one-bit step per edge; count holds remaining steps (>=1)
// DONE  | result valid, done=1 for this one cycle, back to IDLE next
module shift_reg_unit (
  input  logic             clk,
  input  logic             reset,
  shift_reg_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t      state, state_nxt;
  logic [31:0] data_q, data_nxt;
  logic [1:0]  op_q, op_nxt;
  logic [4:0]  count_q, count_nxt;

  function automatic logic [31:0] step1(input logic [1:0] op, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      OP_SLL:  r = {d[30:0], 1'b0};
      OP_SRL:  r = {1'b0, d[31:1]};
      OP_SRA:  r = {d[31], d[31:1]};
      OP_ROR:  r = {d[0], d[31:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Next-state and next-datapath decode; everything holds unless a case says otherwise.
  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    op_nxt    = op_q;
    count_nxt = count_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          data_nxt  = bus.shift_in;
          op_nxt    = bus.shift_op;
          count_nxt = bus.shift_amt;
          state_nxt = (bus.shift_amt != 5'd0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        data_nxt = step1(op_q, data_q);
        // Saturating decrement: count is never zero here, but guard anyway.
        count_nxt = (count_q != 5'd0) ? count_q - 5'd1 : 5'd0;
        if (count_q <= 5'd1) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Working register, captured op and remaining-step counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= 32'd0;
      op_q    <= 2'b00;
      count_q <= 5'd0;
    end else begin
      data_q  <= data_nxt;
      op_q    <= op_nxt;
      count_q <= count_nxt;
    end
  end

  // Status is a pure decode of the state register, so start never reaches it combinationally.
  assign bus.shift_out = data_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_shift_reg_unit.sv
// Directed bench for shift_reg_unit with hand-computed expected values.
module tb_shift_reg_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  shift_reg_unit_if bus ();

  shift_reg_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Watch the unit from the current cycle (index 0) until it returns to IDLE.
  task automatic monitor(output int busy_cnt, output int done_at, output int pulses);
    busy_cnt = 0;
    done_at  = -1;
    pulses   = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus.busy) break;
      busy_cnt++;
      if (bus.done) begin
        pulses++;
        if (done_at < 0) done_at = k;
      end
      tick();
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] din,
                        input logic [4:0] amt, input logic [31:0] exp);
    int bc, da, pc;
    bus.start     = 1'b1;
    bus.shift_op  = op;
    bus.shift_in  = din;
    bus.shift_amt = amt;
    tick();
    bus.start     = 1'b0;
    bus.shift_op  = ~op;
    bus.shift_in  = ~din;
    bus.shift_amt = ~amt;
    chk({tag, "_capture"}, bus.shift_out, din);
    monitor(bc, da, pc);
    chk({tag, "_done_at"}, da, {27'd0, amt});
    chk({tag, "_busy_cycles"}, bc, {27'd0, amt} + 32'd1);
    chk({tag, "_pulses"}, pc, 32'd1);
    chk({tag, "_result"}, bus.shift_out, exp);
    tick();
    chk({tag, "_hold"}, bus.shift_out, exp);
  endtask

  initial begin
    int bc, da, pc;
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.shift_op  = 2'b00;
    bus.shift_amt = 5'd0;
    bus.shift_in  = 32'd0;

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_out", bus.shift_out, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Main function
    run_op("sll4",    2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010);
    run_op("sra31",   2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_op("srl31",   2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
    run_op("sll_z",   2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    run_op("ror_z",   2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    run_op("ror8",    2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456);
    run_op("sll31",   2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000);
    run_op("sra_pos", 2'b10, 32'h4000_0000, 5'd2,  32'h1000_0000);

    // ROR then start held through the done cycle
    bus.start = 1'b1; bus.shift_op = 2'b11; bus.shift_in = 32'h0000_0003; bus.shift_amt = 5'd1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("b2b_done", {31'd0, bus.done}, 32'd1);
    chk("b2b_ror", bus.shift_out, 32'h8000_0001);
    bus.start = 1'b1; bus.shift_op = 2'b00; bus.shift_in = 32'h0000_0005; bus.shift_amt = 5'd2;
    tick();
    chk("b2b_ignored_busy", {31'd0, bus.busy}, 32'd0);
    chk("b2b_ignored_out", bus.shift_out, 32'h8000_0001);
    tick();
    bus.start = 1'b0;
    chk("b2b_accept_busy", {31'd0, bus.busy}, 32'd1);
    chk("b2b_accept_out", bus.shift_out, 32'h0000_0005);
    tick();
    tick();
    chk("b2b_second_done", {31'd0, bus.done}, 32'd1);
    chk("b2b_second_out", bus.shift_out, 32'h0000_0014);
    tick();

    // Busy protection: re-pulse start at E3
    bus.start = 1'b1; bus.shift_op = 2'b00; bus.shift_in = 32'h0000_0001; bus.shift_amt = 5'd8;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1; bus.shift_op = 2'b10; bus.shift_in = 32'hFFFF_FFFF; bus.shift_amt = 5'd3;
    tick();
    bus.start = 1'b0;
    monitor(bc, da, pc);
    chk("prot_done_at", da, 32'd5);
    chk("prot_pulses", pc, 32'd1);
    chk("prot_result", bus.shift_out, 32'h0000_0100);
    tick();

    // Async reset mid-SHIFT
    bus.start = 1'b1; bus.shift_op = 2'b01; bus.shift_in = 32'hF000_0000; bus.shift_amt = 5'd10;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("areset_pre_out", bus.shift_out, 32'h0780_0000);
    #2 reset = 1'b1;
    #1;
    chk("areset_out", bus.shift_out, 32'd0);
    chk("areset_busy", {31'd0, bus.busy}, 32'd0);
    chk("areset_done", {31'd0, bus.done}, 32'd0);
    tick();
    chk("areset_hold_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    tick();
    chk("areset_idle_done", {31'd0, bus.done}, 32'd0);
    run_op("post_rst", 2'b00, 32'h0000_0001, 5'd1, 32'h0000_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_unit.md
SHIFT_REG_UNIT -- requirements
Module: shift_reg_unit

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits and shift amount at 5 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a shift; sampled only in IDLE.
REQ-005 shift_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-006 shift_amt  input  5  shift distance 0..31, captured with start.
REQ-007 shift_in  input  32  operand from the shift-source mux (A or B register data), captured with start.
REQ-008 shift_out  output  32  working/result register; valid when done=1 and held until next accepted start.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  single-cycle pulse marking result valid.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1 at edge E0: shift_out<=shift_in, op<=shift_op, count<=shift_amt; next state SHIFT if shift_amt!=0, else DONE.
REQ-013 IDLE with start=0: all registers hold; shift_out retains the last result.
REQ-014 SHIFT: each edge shifts shift_out by exactly one bit per captured op and decrements count; when count reaches 1 at an edge, that edge performs the final shift, sets count to 0 and moves to DONE.
REQ-015 One-bit step: SLL fills bit0 with 0; SRL fills bit31 with 0; SRA fills bit31 with the current bit31; ROR moves bit0 into bit31.
REQ-016 DONE: done=1 for exactly this one cycle; next edge returns to IDLE unconditionally.
REQ-017 Latency: for amount N, done SHALL be high in the cycle following edge E0+N (N=0 -> cycle after E0); busy high from the cycle after E0 through the done cycle, i.e. N+1 cycles.
REQ-018 start while busy=1 (SHIFT or DONE) SHALL be ignored; captured op, count and operand SHALL not change.
REQ-019 start asserted in the same cycle as done SHALL be ignored; a new operation is accepted only once in IDLE.
REQ-020 shift_in, shift_op and shift_amt changes after E0 SHALL not affect the operation in progress.
REQ-021 done and busy SHALL be driven from registered state only, with no combinational path from start.
REQ-022 count SHALL never underflow; amounts above 31 are not representable.

Reset
REQ-023 reset=1 SHALL immediately, without waiting for clk, force state=IDLE, shift_out=0, count=0, op=00, busy=0, done=0.
REQ-024 reset asserted mid-SHIFT or in DONE SHALL abort the operation without a done pulse; the first start after reset release SHALL be accepted normally.

Verification
REQ-025 SLL: shift_in=0x00000001, amt=4, start at E0 -> busy high 5 cycles, done in cycle after E4, shift_out=0x00000010.
REQ-026 SRA/SRL: shift_in=0x80000000, amt=31 -> SRA gives 0xFFFFFFFF, SRL gives 0x00000001, done in cycle after E31.
REQ-027 Zero amount: shift_in=0xDEADBEEF, amt=0, any op -> done in cycle after E0, shift_out=0xDEADBEEF, busy high 1 cycle.
REQ-028 ROR: shift_in=0x00000003, amt=1 -> shift_out=0x80000001; back-to-back start asserted during done is ignored, accepted on the following cycle in IDLE.
REQ-029 Busy protection: start SLL 0x1 amt=8, re-pulse start with shift_in=0xFFFFFFFF at E3 -> final shift_out=0x00000100, single done pulse.
REQ-030 Async reset: start SRL 0xF0000000 amt=10, assert reset between edges after E5 -> shift_out=0, busy=0 before the next edge, no done; subsequent SLL 0x1 amt=1 yields 0x00000002.
